mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the data-memory access in the MEM stage: latches an EX-stage load/store, drives a
//  req/ack data-RAM port, stalls the pipeline until the access completes, then returns the
//  size/sign-adjusted load value for the MEM pipeline register. Sits between the EX/MEM register
//  and the data RAM; flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT  16  BUSY cycles without dmem_ack before the access is abandoned (>=1)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   synchronous, active-high reset
//  EX_mem_en       in   1   EX stage holds a load/store this cycle
//  EX_mem_wr       in   1   1 = store, 0 = load
//  EX_funct3       in   3   RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  EX_alu_val      in   32  effective byte address
//  EX_rs2_val      in   32  store data (low bits used)
//  dmem_req        out  1   access request to data RAM
//  dmem_we         out  1   write enable, valid with dmem_req
//  dmem_addr       out  32  word address {addr[31:2],2'b00}
//  dmem_be         out  4   byte enables
//  dmem_wdata      out  32  lane-replicated store data
//  dmem_rdata      in   32  read word, valid with dmem_ack
//  dmem_ack        in   1   access complete
//  stall           out  1   freeze IF/ID/EX and EX/MEM register
//  MEM_load_val    out  32  extended load result
//  MEM_load_valid  out  1   one-cycle pulse: MEM_load_val valid
//  misalign_err    out  1   one-cycle pulse: misaligned access rejected
//  bus_err         out  1   one-cycle pulse: timeout
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs 0 (dmem_*, MEM_load_val, pulses, counter).
//  States IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: EX_mem_en & aligned -> latch addr/we/funct3/wdata/be, go BUSY; stall=1 combinationally
//   this cycle. Misaligned (H with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111 treated as W)
//   -> misalign_err pulse next cycle, no request, no stall, stay IDLE.
//  BUSY: dmem_req=1 held with stable addr/we/be/wdata; stall=1. dmem_ack sampled here -> capture
//   rdata, go DONE. Cycle counter increments each BUSY cycle without ack; on reaching TIMEOUT:
//   bus_err pulse, MEM_load_val=0, go DONE. Ack on the TIMEOUT cycle wins (no bus_err).
//  DONE: dmem_req=0, stall=0, MEM_load_valid=1 for loads only (stores: no pulse); go IDLE.
//   EX_mem_en in DONE is ignored (the stalled instruction is leaving); next access accepted in IDLE.
//  Latency: ack in first BUSY cycle -> stall high 2 cycles, MEM_load_valid in 3rd cycle.
//  Byte enables: B -> 1<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
//  wdata: B {4{rs2[7:0]}}; H {2{rs2[15:0]}}; W rs2.
//  Load extract: lane = rdata>>(8*addr[1:0]); B/H sign-extend, BU/HU zero-extend, W pass.
//  Stores: dmem_rdata ignored; MEM_load_val unchanged.
//  rst mid-BUSY: next edge -> IDLE, dmem_req=0, stall=0, no pulses; late ack in IDLE ignored.
//  dmem_ack outside BUSY: ignored.
// TESTING
//  LW addr 0x100, ack 1st BUSY cycle, rdata 0xDEADBEEF -> stall 2 cyc, be 1111, load_val 0xDEADBEEF.
//  LB addr 0x103, rdata 0x80112233 -> be 1000, MEM_load_val 0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x102, rs2 0x0000ABCD -> dmem_we=1, be 1100, wdata 0xABCDABCD, no MEM_load_valid.
//  LW addr 0x102 -> misalign_err one pulse, dmem_req never 1, stall 0.
//  LW, ack withheld, TIMEOUT=16 -> 16 BUSY cycles, bus_err pulse, MEM_load_val 0, stall drops.
//  LW, rst in 2nd BUSY cycle, ack next cycle -> IDLE, dmem_req 0, no load_valid, no errors.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: accepts an EX load/store, runs a req/ack RAM access,
// stalls the pipeline until it finishes, and returns the size/sign-adjusted load value.
module mem_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_mem_en,
   input  logic        EX_mem_wr,
   input  logic [2:0]  EX_funct3,
   input  logic [31:0] EX_alu_val,
   input  logic [31:0] EX_rs2_val,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic [31:0] MEM_load_val,
   output logic        MEM_load_valid,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic [2:0]    f3_q;
   logic [1:0]    lo_q;
   logic          wr_q;

   logic          size_b, size_h, size_w, aligned, accept, reject, timeout_hit;
   logic [3:0]    be_calc;
   logic [31:0]   wdata_calc, lane, load_ext;

   // funct3[1:0] selects the size; 011/110/111 fall into the word case
   assign size_b  = (EX_funct3[1:0] == 2'b00);
   assign size_h  = (EX_funct3[1:0] == 2'b01);
   assign size_w  = ~size_b & ~size_h;
   assign aligned = size_b | (size_h & ~EX_alu_val[0]) | (size_w & (EX_alu_val[1:0] == 2'b00));
   assign accept  = (state == IDLE) & EX_mem_en & aligned;
   assign reject  = (state == IDLE) & EX_mem_en & ~aligned;
   assign timeout_hit = (state == BUSY) & ~dmem_ack & (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = EX_rs2_val;
      if (size_b) begin
         be_calc    = 4'b0001 << EX_alu_val[1:0];
         wdata_calc = {4{EX_rs2_val[7:0]}};
      end else if (size_h) begin
         be_calc    = 4'b0011 << EX_alu_val[1:0];
         wdata_calc = {2{EX_rs2_val[15:0]}};
      end
   end

   assign lane = dmem_rdata >> {lo_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // stall rises combinationally in the accepting IDLE cycle so EX/MEM holds the instruction
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = BUSY;
               stall      = 1'b1;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (dmem_ack || timeout_hit) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_be        <= '0;
         dmem_wdata     <= '0;
         MEM_load_val   <= '0;
         MEM_load_valid <= 1'b0;
         misalign_err   <= 1'b0;
         bus_err        <= 1'b0;
         cnt            <= '0;
         f3_q           <= '0;
         lo_q           <= '0;
         wr_q           <= 1'b0;
      end else begin
         MEM_load_valid <= 1'b0;
         misalign_err   <= 1'b0;
         bus_err        <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= EX_mem_wr;
                  dmem_addr  <= {EX_alu_val[31:2], 2'b00};
                  dmem_be    <= be_calc;
                  dmem_wdata <= wdata_calc;
                  f3_q       <= EX_funct3;
                  lo_q       <= EX_alu_val[1:0];
                  wr_q       <= EX_mem_wr;
                  cnt        <= '0;
               end else if (reject) begin
                  misalign_err <= 1'b1;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (!wr_q) begin
                     MEM_load_val   <= load_ext;
                     MEM_load_valid <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  bus_err  <= 1'b1;
                  if (!wr_q) begin
                     MEM_load_val   <= '0;
                     MEM_load_valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses checked against a
// byte-lane arithmetic model of RV32I load/store sizing.
module tb_mem_access_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        EX_mem_en = 1'b0, EX_mem_wr = 1'b0;
   logic [2:0]  EX_funct3 = '0;
   logic [31:0] EX_alu_val = '0, EX_rs2_val = '0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic        stall;
   logic [31:0] MEM_load_val;
   logic        MEM_load_valid, misalign_err, bus_err;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_val = '0;

   mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .EX_mem_en(EX_mem_en), .EX_mem_wr(EX_mem_wr), .EX_funct3(EX_funct3),
      .EX_alu_val(EX_alu_val), .EX_rs2_val(EX_rs2_val),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .MEM_load_val(MEM_load_val), .MEM_load_valid(MEM_load_valid),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                              input logic [31:0] rdata);
      int n;
      logic [31:0] mask, v;
      n = nbytes(f3);
      if (n == 4) return rdata;
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = (rdata >> (8 * off)) & mask;
      if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   // ack_delay: BUSY cycles before ack (0 = first BUSY cycle); >= TIMEOUT means never ack
   task automatic do_access(input logic [2:0] f3, input logic wr, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [31:0] rdata, input int ack_delay);
      int n, off, k, exp_k;
      logic al, to;
      logic [3:0] e_be;
      logic [31:0] e_wd, e_lv;
      n = nbytes(f3);
      off = int'(addr[1:0]);
      al = ((off % n) == 0);
      to = (ack_delay >= TIMEOUT);
      e_be = 4'(((1 << n) - 1) << off);
      e_wd = (n == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
             (n == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
      @(negedge clk);
      total++; if ({dmem_req, misalign_err, bus_err, MEM_load_valid} !== 4'b0) begin bad++;
         $display("FAIL idle_quiet: req/mis/bus/lv=%b exp 0000", {dmem_req, misalign_err, bus_err, MEM_load_valid}); end
      EX_funct3 = f3; EX_mem_wr = wr; EX_alu_val = addr; EX_rs2_val = rs2; EX_mem_en = 1'b1;
      #1;
      total++; if (stall !== al) begin bad++; $display("FAIL accept_stall: got %b exp %b", stall, al); end
      @(negedge clk);
      EX_mem_en = 1'b0;
      #1;
      if (!al) begin
         total++; if ({misalign_err, dmem_req, stall} !== 3'b100) begin bad++;
            $display("FAIL misalign: mis/req/stall=%b exp 100", {misalign_err, dmem_req, stall}); end
         return;
      end
      k = 0;
      while (dmem_req === 1'b1 && k < TIMEOUT + 2) begin
         total++; if ({stall, dmem_we, dmem_be} !== {1'b1, wr, e_be} || dmem_addr !== {addr[31:2], 2'b00}
                      || dmem_wdata !== e_wd) begin bad++;
            $display("FAIL busy_port: stall=%b we=%b be=%b addr=%h wd=%h exp 1 %b %b %h %h",
                     stall, dmem_we, dmem_be, dmem_addr, dmem_wdata, wr, e_be, {addr[31:2], 2'b00}, e_wd); end
         dmem_ack = (k == ack_delay);
         dmem_rdata = dmem_ack ? rdata : $urandom;
         k++;
         @(negedge clk);
         dmem_ack = 1'b0;
         #1;
      end
      exp_k = to ? TIMEOUT : ack_delay + 1;
      total++; if (k !== exp_k) begin bad++; $display("FAIL busy_cycles: got %0d exp %0d", k, exp_k); end
      total++; if ({stall, bus_err, misalign_err} !== {1'b0, to, 1'b0}) begin bad++;
         $display("FAIL done_flags: stall/bus/mis=%b exp 0%b0", {stall, bus_err, misalign_err}, to); end
      if (!to) begin
         total++; if (MEM_load_valid !== !wr) begin bad++;
            $display("FAIL load_valid: got %b exp %b", MEM_load_valid, !wr); end
      end
      e_lv = wr ? last_val : (to ? 32'd0 : model_load(f3, off, rdata));
      exp_q.push_back(e_lv);
      last_val = e_lv;
      total++; if (MEM_load_val !== exp_q[0]) begin bad++;
         $display("FAIL load_val: got %h exp %h", MEM_load_val, exp_q[0]); end
      void'(exp_q.pop_front());
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if ({dmem_req, dmem_we, dmem_be, stall, MEM_load_valid, misalign_err, bus_err} !== 10'b0
                   || dmem_addr !== 0 || dmem_wdata !== 0 || MEM_load_val !== 0) begin bad++;
         $display("FAIL reset_outputs: req=%b be=%b stall=%b lv=%h", dmem_req, dmem_be, stall, MEM_load_val); end
      rst = 1'b0;
      last_val = '0;
   endtask

   task automatic test_lw();       do_access(3'b010, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0); endtask

   task automatic test_lb_lbu();
      do_access(3'b000, 1'b0, 32'h103, 32'h0, 32'h80112233, 0);
      do_access(3'b100, 1'b0, 32'h103, 32'h0, 32'h80112233, 1);
      do_access(3'b001, 1'b0, 32'h102, 32'h0, 32'h8001F234, 2);
      do_access(3'b101, 1'b0, 32'h102, 32'h0, 32'h8001F234, 0);
   endtask

   task automatic test_store();
      do_access(3'b001, 1'b1, 32'h102, 32'h0000ABCD, 32'h12345678, 0);
      do_access(3'b000, 1'b1, 32'h101, 32'h000000A5, 32'h0, 3);
      do_access(3'b010, 1'b1, 32'h104, 32'hCAFEF00D, 32'h0, 1);
   endtask

   task automatic test_misalign();
      do_access(3'b010, 1'b0, 32'h102, 32'h0, 32'h0, 0);
      do_access(3'b001, 1'b0, 32'h101, 32'h0, 32'h0, 0);
      do_access(3'b111, 1'b1, 32'h203, 32'h0, 32'h0, 0);
   endtask

   task automatic test_timeout();
      do_access(3'b010, 1'b0, 32'h100, 32'h0, 32'h0, 99);
      do_access(3'b010, 1'b0, 32'h108, 32'h0, 32'h13572468, TIMEOUT - 1);
   endtask

   task automatic test_back_to_back();
      do_access(3'b010, 1'b0, 32'h300, 32'h0, 32'h01020304, 0);
      EX_funct3 = 3'b010; EX_mem_wr = 1'b0; EX_alu_val = 32'h304; EX_mem_en = 1'b1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL done_ignores_en: stall=%b exp 0", stall); end
      do_access(3'b010, 1'b0, 32'h304, 32'h0, 32'h0A0B0C0D, 0);
   endtask

   task automatic test_rst_mid_busy();
      @(negedge clk);
      EX_funct3 = 3'b010; EX_mem_wr = 1'b0; EX_alu_val = 32'h100; EX_mem_en = 1'b1;
      @(negedge clk);
      EX_mem_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      #1;
      total++; if ({dmem_req, stall, MEM_load_valid, misalign_err, bus_err} !== 5'b0) begin bad++;
         $display("FAIL rst_busy: req/stall/lv/mis/bus=%b exp 00000", {dmem_req, stall, MEM_load_valid, misalign_err, bus_err}); end
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      total++; if ({dmem_req, MEM_load_valid, misalign_err, bus_err} !== 4'b0 || MEM_load_val !== 0) begin bad++;
         $display("FAIL late_ack: req/lv/mis/bus=%b val=%h exp 0000 0", {dmem_req, MEM_load_valid, misalign_err, bus_err}, MEM_load_val); end
      last_val = '0;
   endtask

   task automatic test_random();
      logic [2:0] f3s[8];
      logic [2:0] f3;
      logic wr;
      int d;
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         f3 = wr ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 7)];
         d = ($urandom_range(0, 9) == 0 && !wr) ? 40 : $urandom_range(0, 3);
         do_access(f3, wr, 32'h1000 + $urandom_range(0, 255), $urandom, $urandom, d);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_store();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_rst_mid_busy();
      test_random();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
